// File: rtl/regfile_mp_if.sv
// Register-file port bundle: write ports from writeback, read ports from decode.
// Packed buses keep port i at [i*W +: W] so the widths track the parameters.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  // Write ports carry no handshake: a write is taken on any posedge where it is
  // effective (we & ~stallW & ready & wa != 0). ready is the only flow signal.
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic                     ready;
  logic                     wr_conflict;

  modport master (
    output we, wa, wd, ra,
    input  rd, ready, wr_conflict
  );

  modport slave (
    input  we, wa, wd, ra,
    output rd, ready, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle bypass, highest-port-wins writes and a
// sequential clear sweep run after reset or on clear_req.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stallW,
  input  logic              clear_req,
  regfile_mp_if.slave       bus,
  output logic              dbg_in_clear,
  output logic [ADDR_W-1:0] dbg_clr_ptr
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wr_conflict_q, wr_conflict_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                ready;
  logic [NUM_WR-1:0]   eff_we;
  logic [ADDR_W-1:0]   wa_p [NUM_WR];
  logic [DATA_W-1:0]   wd_p [NUM_WR];
  logic [ADDR_W-1:0]   ra_p [NUM_RD];
  logic [DATA_W-1:0]   rd_p [NUM_RD];

  assign ready = (state_q == ST_RUN);

  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wa_p[i] = bus.wa[i*ADDR_W +: ADDR_W];
      wd_p[i] = bus.wd[i*DATA_W +: DATA_W];
    end
    for (int j = 0; j < NUM_RD; j++) begin
      ra_p[j] = bus.ra[j*ADDR_W +: ADDR_W];
    end
  end

  // Effective writes: never to r0, never while stalled, never during the sweep.
  always_comb begin
    eff_we = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      eff_we[i] = bus.we[i] & ~stallW & ready & (wa_p[i] != '0);
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (eff_we[i] && eff_we[j] && (wa_p[i] == wa_p[j])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        // clear_req is ignored here so an in-progress sweep never restarts.
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_CLEAR;
      ptr_q         <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Storage has no reset; the sweep zeroes it. Ascending port order lets the
  // highest-index port win a same-address collision.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (eff_we[i]) begin
          mem_q[wa_p[i]] <= wd_p[i];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rd_p[j] = '0;
      if (ready && (ra_p[j] != '0)) begin
        rd_p[j] = mem_q[ra_p[j]];
        if (BYPASS) begin
          for (int i = 0; i < NUM_WR; i++) begin
            if (eff_we[i] && (wa_p[i] == ra_p[j])) begin
              rd_p[j] = wd_p[i];
            end
          end
        end
      end
    end
  end

  always_comb begin
    bus.rd = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      bus.rd[j*DATA_W +: DATA_W] = rd_p[j];
    end
  end

  assign bus.ready       = ready;
  assign bus.wr_conflict = wr_conflict_q;
  assign dbg_in_clear    = (state_q == ST_CLEAR);
  assign dbg_clr_ptr     = ptr_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus
// and are compared every cycle against an array model of the register file.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic stallW = 1'b0;
  logic clear_req = 1'b0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_b ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_n ();

  logic          dbg_clr_b, dbg_clr_n;
  logic [AW-1:0] dbg_ptr_b, dbg_ptr_n;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .stallW(stallW), .clear_req(clear_req),
    .bus(bus_b.slave), .dbg_in_clear(dbg_clr_b), .dbg_clr_ptr(dbg_ptr_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b0)) dut_n (
    .clk(clk), .resetn(resetn), .stallW(stallW), .clear_req(clear_req),
    .bus(bus_n.slave), .dbg_in_clear(dbg_clr_n), .dbg_clr_ptr(dbg_ptr_n)
  );

  logic [NW-1:0] we_v;
  logic [AW-1:0] wa_v [NW];
  logic [DW-1:0] wd_v [NW];
  logic [AW-1:0] ra_v [NR];

  always_comb begin
    bus_b.we = we_v;
    bus_n.we = we_v;
    bus_b.wa = '0;
    bus_n.wa = '0;
    bus_b.wd = '0;
    bus_n.wd = '0;
    bus_b.ra = '0;
    bus_n.ra = '0;
    for (int i = 0; i < NW; i++) begin
      bus_b.wa[i*AW +: AW] = wa_v[i];
      bus_n.wa[i*AW +: AW] = wa_v[i];
      bus_b.wd[i*DW +: DW] = wd_v[i];
      bus_n.wd[i*DW +: DW] = wd_v[i];
    end
    for (int j = 0; j < NR; j++) begin
      bus_b.ra[j*AW +: AW] = ra_v[j];
      bus_n.ra[j*AW +: AW] = ra_v[j];
    end
  end

  // Reference model: register contents, cycles left before ready, conflict flag.
  logic [DW-1:0] m_mem [DEPTH];
  int            clr_left;
  logic          m_conf;

  int tests = 0;
  int fails = 0;

  function automatic logic m_ready();
    return (clr_left == 0);
  endfunction

  function automatic logic eff(int i);
    return we_v[i] && !stallW && m_ready() && (wa_v[i] != 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(int j, bit byp);
    logic [DW-1:0] v;
    v = '0;
    if (m_ready() && ra_v[j] != 0) begin
      v = m_mem[ra_v[j]];
      if (byp) begin
        for (int i = 0; i < NW; i++) begin
          if (eff(i) && wa_v[i] == ra_v[j]) v = wd_v[i];
        end
      end
    end
    return v;
  endfunction

  task automatic model_zero();
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
  endtask

  task automatic model_reset();
    clr_left = DEPTH;
    m_conf   = 1'b0;
    model_zero();
  endtask

  task automatic model_edge();
    int   hits [DEPTH];
    logic e [NW];
    if (!resetn) return;
    if (clr_left > 0) begin
      clr_left--;
      m_conf = 1'b0;
      return;
    end
    for (int a = 0; a < DEPTH; a++) hits[a] = 0;
    for (int i = 0; i < NW; i++) e[i] = eff(i);
    m_conf = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (e[i]) begin
        hits[wa_v[i]]++;
        if (hits[wa_v[i]] >= 2) m_conf = 1'b1;
        m_mem[wa_v[i]] = wd_v[i];
      end
    end
    if (clear_req) begin
      clr_left = DEPTH;
      model_zero();
    end
  endtask

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int j = 0; j < NR; j++) begin
      check("rd_bypass", bus_b.rd[j*DW +: DW], exp_rd(j, 1'b1));
      check("rd_nobypass", bus_n.rd[j*DW +: DW], exp_rd(j, 1'b0));
    end
    check("ready_b", DW'(bus_b.ready), DW'(m_ready()));
    check("ready_n", DW'(bus_n.ready), DW'(m_ready()));
    check("conflict_b", DW'(bus_b.wr_conflict), DW'(m_conf));
    check("conflict_n", DW'(bus_n.wr_conflict), DW'(m_conf));
  endtask

  // One cycle: let inputs settle, compare, clock, update the model.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we_v = '0;
    for (int i = 0; i < NW; i++) begin
      wa_v[i] = '0;
      wd_v[i] = '0;
    end
    for (int j = 0; j < NR; j++) ra_v[j] = '0;
  endtask

  task automatic wait_ready(string tag, bit rand_wr);
    int n;
    n = 0;
    while (!bus_b.ready && n < 100) begin
      if (rand_wr) begin
        we_v = 2'b11;
        for (int i = 0; i < NW; i++) begin
          wa_v[i] = AW'($urandom_range(1, DEPTH - 1));
          wd_v[i] = $urandom;
        end
        clear_req = (n == 5);
      end
      tick();
      n++;
    end
    clear_req = 1'b0;
    idle();
    check(tag, DW'(n), DW'(DEPTH));
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      ra_v[0] = AW'(a);
      ra_v[1] = AW'(DEPTH - 1 - a);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    model_reset();
    repeat (3) tick();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_ready("reset_clear_len", 1'b0);
    read_all();

    // Same-cycle write and read of r5 on port 0.
    we_v = 2'b01; wa_v[0] = 5; wd_v[0] = 32'hDEADBEEF; ra_v[0] = 5;
    #1;
    check("bypass_same_cycle", bus_b.rd[DW-1:0], 32'hDEADBEEF);
    check("nobypass_same_cycle", bus_n.rd[DW-1:0], 32'h0);
    tick();
    we_v = '0;
    #1;
    check("nobypass_next_cycle", bus_n.rd[DW-1:0], 32'hDEADBEEF);
    tick();

    // Both ports hit r7: port 1 wins, conflict flag for one cycle.
    we_v = 2'b11; wa_v[0] = 7; wa_v[1] = 7;
    wd_v[0] = 32'h11111111; wd_v[1] = 32'h22222222; ra_v[0] = 7; ra_v[1] = 7;
    #1;
    check("bypass_priority", bus_b.rd[DW-1:0], 32'h22222222);
    tick();
    we_v = '0;
    #1;
    check("priority_array", bus_n.rd[DW +: DW], 32'h22222222);
    check("conflict_set", DW'(bus_b.wr_conflict), 32'h1);
    tick();
    check("conflict_cleared", DW'(bus_b.wr_conflict), 32'h0);

    // r0 is never written and writing it is not a conflict.
    we_v = 2'b11; wa_v[0] = 0; wa_v[1] = 0; wd_v[0] = '1; wd_v[1] = '1; ra_v[0] = 0;
    #1;
    check("r0_bypass", bus_b.rd[DW-1:0], 32'h0);
    tick();
    we_v = '0;
    #1;
    check("r0_no_conflict", DW'(bus_b.wr_conflict), 32'h0);
    tick();

    // Stalled write to r9: no bypass, no commit.
    stallW = 1'b1; we_v = 2'b01; wa_v[0] = 9; wd_v[0] = 32'h1234; ra_v[0] = 9;
    #1;
    check("stall_no_bypass", bus_b.rd[DW-1:0], 32'h0);
    tick();
    stallW = 1'b0; we_v = '0;
    #1;
    check("stall_no_commit", bus_n.rd[DW-1:0], 32'h0);
    tick();

    // Fill r1..r31 with their index, then sweep on request.
    for (int a = 1; a < DEPTH; a++) begin
      we_v = 2'b10; wa_v[1] = AW'(a); wd_v[1] = DW'(a); ra_v[0] = AW'(a - 1);
      tick();
    end
    idle();
    read_all();
    clear_req = 1'b1; ra_v[0] = 3;
    tick();
    clear_req = 1'b0;
    #1;
    check("clear_ready_low", DW'(bus_b.ready), 32'h0);
    check("clear_rd_zero", bus_b.rd[DW-1:0], 32'h0);
    wait_ready("clear_req_len", 1'b1);
    read_all();

    // Reset in the middle of a sweep restarts it from entry 0.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    check("mid_clear_ptr", DW'(dbg_ptr_b), 32'd10);
    resetn = 1'b0;
    model_reset();
    #1;
    check("reset_ptr_zero", DW'(dbg_ptr_b), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    wait_ready("reset_mid_clear_len", 1'b0);
    read_all();

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      stallW    = ($urandom_range(0, 3) == 0);
      clear_req = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NW; i++) begin
        we_v[i] = ($urandom_range(0, 3) != 0);
        wa_v[i] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                              : AW'($urandom_range(0, DEPTH - 1));
        wd_v[i] = $urandom;
      end
      for (int j = 0; j < NR; j++) begin
        ra_v[j] = ($urandom_range(0, 1) != 0) ? wa_v[$urandom_range(0, NW - 1)]
                                              : AW'($urandom_range(0, DEPTH - 1));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the MIPS pipeline.
- Successor to the single-issue 2R/1W regfile: it generalises data width, depth and the number of read/write ports so it can serve the dual-issue datapath.
- Adds same-cycle write-to-read bypass, deterministic write-port priority, and a sequential clear engine that zeroes the array after reset or on request.
- Sits between decode (reads) and writeback (writes).

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of read ports (valid range 1..6).
- NUM_WR, 2, number of write ports (valid range 1..4).
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns array contents only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- stallW  in  1  writeback stall; when 1, all writes are suppressed.
- clear_req  in  1  synchronous pulse; starts a full array clear.
- we  in  NUM_WR  per-port write enable.
- wa  in  NUM_WR*ADDR_W  packed write addresses; port i is bits [i*ADDR_W +: ADDR_W].
- wd  in  NUM_WR*DATA_W  packed write data.
- ra  in  NUM_RD*ADDR_W  packed read addresses.
- rd  out  NUM_RD*DATA_W  packed read data, combinational.
- ready  out  1  high when the array is valid and accepting writes.
- wr_conflict  out  1  registered; high for one cycle after two or more effective writes targeted the same address.

Behaviour:
- Reset (resetn=0, asynchronous):
  - FSM forced to CLEAR; clear pointer = 0.
  - ready=0, wr_conflict=0.
  - rd forced to 0 while in CLEAR.
  - Array contents are not reset directly.
- FSM has two states:
  - CLEAR: each cycle writes 0 to entry[ptr], then ptr++. When ptr reaches 2**ADDR_W-1 and that entry is written, go to RUN next cycle. CLEAR therefore lasts exactly 2**ADDR_W cycles after resetn rises.
  - RUN: ready=1; normal operation.
  - clear_req=1 in RUN: go to CLEAR next cycle, ptr=0. Writes in that same cycle still commit.
  - clear_req while already in CLEAR: ignored; the sweep does not restart.
- Effective write on port i: we[i] & ~stallW & ready & (wa_i != 0).
  - Register 0 is never written and always reads 0.
  - All writes in CLEAR are dropped, including stallW-independent ones.
- Write timing: commits on posedge clk; visible in the array from the next cycle.
- Same-address priority: if several effective writes target one address, the highest-index port wins.
  - wr_conflict=1 on the following cycle; otherwise wr_conflict=0.
  - wr_conflict is a diagnostic flag only.
- Read port j (combinational):
  - ready=0: rd_j = 0.
  - ra_j == 0: rd_j = 0.
  - BYPASS=1 and any effective write matches ra_j this cycle: rd_j = wd of the highest-index matching port.
  - Otherwise: rd_j = entry[ra_j].
  - Bypass never applies when stallW=1 or during CLEAR.
- Read ports are independent; every port may read the same address.
- Widths:
  - Addresses are unsigned; no range check is needed because depth = 2**ADDR_W.
  - Data is stored unmodified.
- Reset asserted mid-CLEAR: restarts CLEAR at ptr=0.
- Reset asserted mid-RUN: any in-flight write that cycle is lost.

Test Plan:
- Reset release, DATA_W=32, ADDR_W=5: ready=0 for exactly 32 cycles, then 1. Reading all 32 addresses returns 0x00000000.
- Port 0 writes r5=0xDEADBEEF with ra0=5 in the same cycle, BYPASS=1: rd0=0xDEADBEEF in that cycle, and the array holds it next cycle. Repeat with BYPASS=0: old value 0 in the write cycle, 0xDEADBEEF the cycle after.
- Port 0 writes r7=0x11111111 and port 1 writes r7=0x22222222 in one cycle: read r7 = 0x22222222; wr_conflict=1 for exactly one cycle.
- Write r0=0xFFFFFFFF on both ports: r0 reads 0, wr_conflict stays 0. Write r9=0x1234 with stallW=1: r9 unchanged, no bypass.
- Fill r1..r31 with their index, pulse clear_req: next cycle ready=0 and rd=0. After 32 cycles ready=1 and all registers read 0. Writes attempted during the sweep are dropped.
- Drop resetn at ptr=10 mid-CLEAR, release after 3 cycles: a full 32-cycle CLEAR follows before ready=1.
